// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types and constants for the SRAM data-memory responder.
package dbus_sram_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE1,
        MSIZE2,
        MSIZE4,
        MSIZE8
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    localparam logic [63:0] DMEM_BASE = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dsram_state_t;

endpackage

// File: rtl/dbus_sram_responder_sram.sv
// Word-wide single-port SRAM: combinational read, byte-enabled synchronous write.
module sram_1rw_be #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [63:0]           rdata,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [7:0]            wbe,
    input  logic [63:0]           wdata
);

    logic [63:0] mem [2**DEPTH_LOG2];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder: fixed-latency SRAM window with byte-strobed writes and counters.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2,
    parameter logic [63:0] BASE       = DMEM_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic [63:0] txn_count,
    output logic [31:0] oob_count
);

    localparam logic [63:0] SPAN     = 64'(1) << (DEPTH_LOG2 + 3);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dsram_state_t          state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  inwin_q, inwin_d;
    logic [7:0]            strobe_q, strobe_d;
    logic [63:0]           wdata_q, wdata_d;
    logic [63:0]           txn_q, txn_d;
    logic [31:0]           oob_q, oob_d;

    logic [63:0] off;
    logic        req_inwin;
    logic [63:0] rdata;
    logic        we;
    logic        unused_size;

    assign unused_size = ^dreq.size;

    always_comb begin
        off       = dreq.addr - BASE;
        req_inwin = (dreq.addr >= BASE) && (off < SPAN);
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        inwin_d   = inwin_q;
        strobe_d  = strobe_q;
        wdata_d   = wdata_q;
        txn_d     = txn_q;
        oob_d     = oob_q;
        dresp     = '0;
        we        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    idx_d    = off[DEPTH_LOG2+2:3];
                    inwin_d  = req_inwin;
                    strobe_d = dreq.strobe;
                    wdata_d  = dreq.data;
                    cnt_d    = CNT_INIT;
                    state_d  = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // A reset landing on the response cycle cancels both the pulse and the write.
                if (!reset) begin
                    dresp.addr_ok = 1'b1;
                    dresp.data_ok = 1'b1;
                    dresp.data    = inwin_q ? rdata : 64'd0;
                end
                we      = inwin_q && (strobe_q != 8'd0) && !reset;
                txn_d   = txn_q + 64'd1;
                oob_d   = oob_q + {31'd0, ~inwin_q};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            inwin_q  <= 1'b0;
            strobe_q <= 8'd0;
            wdata_q  <= 64'd0;
            txn_q    <= 64'd0;
            oob_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            inwin_q  <= inwin_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            txn_q    <= txn_d;
            oob_q    <= oob_d;
        end
    end

    sram_1rw_be #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_sram (
        .clk  (clk),
        .raddr(idx_q),
        .rdata(rdata),
        .we   (we),
        .waddr(idx_q),
        .wbe  (strobe_q),
        .wdata(wdata_q)
    );

    assign txn_count = txn_q;
    assign oob_count = oob_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench: three responders (latency 1, 2, 3) against a word-map model.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam int          N = 3;
    localparam logic [63:0] B = 64'h8000_0000;
    localparam logic [63:0] SPAN = 64'd32768;

    typedef struct {
        logic [63:0]     data;
        bit              chk_data;
        int              ok_cyc;
        longint unsigned tcnt;
        int unsigned     ocnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    dbus_req_t   dreq [N];
    dbus_resp_t  dresp [N];
    logic [63:0] txn [N];
    logic [31:0] oob [N];

    int              cyc = 0;
    int              errors = 0;
    int              checks = 0;
    exp_t            q [N][$];
    logic [63:0]     mem_m [int];
    int              last_ok [N];
    longint unsigned m_txn [N];
    int unsigned     m_oob [N];
    exp_t            mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dbus_sram_responder #(
            .DEPTH_LOG2(12),
            .LATENCY   (g + 1),
            .BASE      (B)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .dreq     (dreq[g]),
            .dresp    (dresp[g]),
            .txn_count(txn[g]),
            .oob_count(oob[g])
        );
    end

    function automatic void chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %h required %h", nm, k, cyc, act, exp);
        end
    endfunction

    function automatic bit in_win(logic [63:0] a);
        return (a >= B) && (a < B + SPAN);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                if (dresp[k].data_ok) begin
                    if (q[k].size() == 0) begin
                        chk("spurious_data_ok", k, 64'd1, 64'd0);
                    end else begin
                        mon_e = q[k].pop_front();
                        chk("resp_cycle", k, 64'(cyc), 64'(mon_e.ok_cyc));
                        chk("addr_ok", k, {63'd0, dresp[k].addr_ok}, 64'd1);
                        if (mon_e.chk_data) chk("rdata", k, dresp[k].data, mon_e.data);
                        chk("txn_at_resp", k, txn[k], mon_e.tcnt);
                        chk("oob_at_resp", k, {32'd0, oob[k]}, {32'd0, mon_e.ocnt});
                    end
                end else begin
                    chk("idle_outputs", k,
                        {63'd0, dresp[k].addr_ok || (dresp[k].data != 64'd0)}, 64'd0);
                end
            end
        end
    end

    task automatic flush();
        for (int k = 0; k < N; k++) begin
            q[k].delete();
            m_txn[k]   = 0;
            m_oob[k]   = 0;
            last_ok[k] = -100;
        end
    endtask

    // Called at a negedge; returns at the negedge where data_ok is seen.
    task automatic txn_op(input int k, input logic [63:0] a, input logic [7:0] s_in,
                          input logic [63:0] d, input bit hold);
        logic [7:0]  s;
        logic [63:0] w;
        int          key;
        int          x;
        int          n;
        bit          win;
        exp_t        e;
        s   = s_in;
        win = in_win(a);
        key = win ? k * 8192 + int'((a - B) >> 3) : -1;
        if (win && s != 8'd0 && !mem_m.exists(key)) s = 8'hFF;
        x          = (cyc > last_ok[k]) ? cyc : last_ok[k] + 1;
        e.ok_cyc   = x + k + 1;
        last_ok[k] = e.ok_cyc;
        e.tcnt     = m_txn[k];
        e.ocnt     = m_oob[k];
        e.chk_data = !win || mem_m.exists(key);
        w          = (win && mem_m.exists(key)) ? mem_m[key] : 64'd0;
        e.data     = w;
        q[k].push_back(e);
        m_txn[k]++;
        if (!win) m_oob[k]++;
        if (win && s != 8'd0) begin
            for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            mem_m[key] = w;
        end
        dreq[k] = '{valid: 1'b1, addr: a, size: MSIZE8, strobe: s, data: d};
        n = 0;
        forever begin
            @(negedge clk);
            if (dresp[k].data_ok) break;
            n++;
            if (n > 40) begin
                chk("data_ok_timeout", k, 64'd0, 64'd1);
                break;
            end
            if (cyc > x) begin
                dreq[k].addr   = {$urandom, $urandom};
                dreq[k].strobe = 8'($urandom);
                dreq[k].data   = {$urandom, $urandom};
            end
        end
        if (!hold) dreq[k].valid = 1'b0;
    endtask

    task automatic chk_counters(input int k);
        @(negedge clk);
        chk("txn_count", k, txn[k], m_txn[k]);
        chk("oob_count", k, {32'd0, oob[k]}, {32'd0, m_oob[k]});
    endtask

    task automatic directed(input int k);
        txn_op(k, B + 64'h10, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
        txn_op(k, B + 64'h10, 8'h00, 64'd0, 1'b0);
        txn_op(k, B + 64'h10, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0);
        txn_op(k, B + 64'h14, 8'h00, 64'd0, 1'b0);
        txn_op(k, 64'h1000, 8'h00, 64'd0, 1'b0);
        txn_op(k, B, 8'hFF, 64'hC0FF_EE00_0000_0001, 1'b0);
        txn_op(k, B + 64'h18, 8'hFF, 64'h5555_6666_7777_8888, 1'b0);
        txn_op(k, B + 8 * 4095, 8'hFF, 64'h0BAD_F00D_DEAD_BEEF, 1'b0);
        txn_op(k, 64'h7FFF_FFF8, 8'hFF, '1, 1'b0);
        txn_op(k, B + SPAN, 8'hFF, '1, 1'b0);
        txn_op(k, B + 8 * 4095, 8'h00, 64'd0, 1'b0);
        txn_op(k, B, 8'h00, 64'd0, 1'b0);
        chk_counters(k);
    endtask

    task automatic random_run(input int k);
        logic [63:0] a;
        int          r;
        for (int i = 0; i < 64; i++) begin
            txn_op(k, B + 64'(8 * (i + 32)), 8'hFF, {$urandom, $urandom}, 1'b0);
        end
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            a = B + 64'(8 * $urandom_range(32, 95)) + 64'($urandom_range(0, 7));
            if (r >= 8) begin
                a = {$urandom, $urandom};
                if (in_win(a)) a[63] = 1'b1;
            end
            txn_op(k, a, (r < 4) ? 8'h00 : 8'($urandom), {$urandom, $urandom},
                   (i != 119) && ($urandom_range(0, 1) == 1));
        end
        chk_counters(k);
    endtask

    task automatic abort(input int k, input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        dreq[k] = '{valid: 1'b1, addr: a, size: MSIZE8, strobe: 8'hFF, data: d};
        @(posedge clk);
        #1;
        reset = 1'b1;
        dreq[k].valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        flush();
        chk("abort_txn", k, txn[k], 64'd0);
        chk("abort_oob", k, {32'd0, oob[k]}, 64'd0);
        txn_op(k, a, 8'h00, 64'd0, 1'b0);
        chk_counters(k);
    endtask

    initial begin
        for (int k = 0; k < N; k++) dreq[k] = '0;
        flush();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("rst_ok", k, {62'd0, dresp[k].addr_ok, dresp[k].data_ok}, 64'd0);
            chk("rst_data", k, dresp[k].data, 64'd0);
            chk("rst_txn", k, txn[k], 64'd0);
            chk("rst_oob", k, {32'd0, oob[k]}, 64'd0);
        end
        for (int k = 0; k < N; k++) directed(k);
        txn_op(0, B, 8'h00, 64'd0, 1'b1);
        txn_op(0, B + 64'h10, 8'h00, 64'd0, 1'b1);
        txn_op(0, B + 8 * 4095, 8'h00, 64'd0, 1'b1);
        txn_op(0, B + 64'h18, 8'h00, 64'd0, 1'b0);
        chk_counters(0);
        for (int k = 0; k < N; k++) random_run(k);
        abort(2, B, 64'h1234_5678_9ABC_DEF0);
        abort(0, B + 64'h10, 64'hFEDC_BA98_7654_3210);
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("queue_drained", k, 64'(q[k].size()), 64'd0);
            chk("final_txn", k, txn[k], m_txn[k]);
            chk("final_oob", k, {32'd0, oob[k]}, {32'd0, m_oob[k]});
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
